// File: rtl/pixel_frame_serializer_if.sv
// pixel_frame_serializer_if: valid/ready byte stream carrying serialized pixel packets
interface pixel_frame_serializer_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;
  modport master (output data, valid, last, input ready);
  modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/pixel_frame_serializer.sv
// pixel_frame_serializer: captures 4-pixel frames from the readout strobes and streams them as 6-byte packets
module pixel_frame_serializer #(
  parameter int              DATA_W      = 8,
  parameter int              FRAME_DEPTH = 2,
  parameter logic [DATA_W-1:0] HEADER    = 8'hA5,
  localparam int             LW          = $clog2(FRAME_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              erase,
  input  logic              read12,
  input  logic              read34,
  input  logic [DATA_W-1:0] pixelDataOut1,
  input  logic [DATA_W-1:0] pixelDataOut2,
  input  logic [DATA_W-1:0] pixelDataOut3,
  input  logic [DATA_W-1:0] pixelDataOut4,
  pixel_frame_serializer_if.master out,
  output logic [LW-1:0]     buf_level,
  output logic              overflow,
  output logic              seq_err,
  input  logic              clear_err
);
  localparam int AW = $clog2(FRAME_DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  typedef logic [4:0][DATA_W-1:0] frame_t;
  frame_t                 mem [FRAME_DEPTH];
  state_t                 state_q, state_d;
  logic                   read12_q, read34_q, erase_q;
  logic                   have12_q, have12_d;
  logic [3:0][DATA_W-1:0] pix_q, pix_d;
  logic [7:0]             seq_q, seq_d;
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]          level_q, level_d;
  logic [2:0]             idx_q, idx_d, nidx, fi;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   valid_q, valid_d, last_q, last_d;
  logic                   overflow_q, overflow_d, seq_err_q, seq_err_d;
  logic                   r34_fall, commit, drop, pop, adv, more, go, stop;
  frame_t                 cur;
  always_comb begin
    r34_fall   = read34_q & ~read34;
    adv        = valid_q & out.ready;
    pop        = adv & last_q;
    // a final-byte pop in the same cycle frees the slot the commit needs
    commit     = r34_fall & have12_q & ((level_q != LW'(FRAME_DEPTH)) | pop);
    drop       = r34_fall & have12_q & ~commit;
    pix_d      = {read12 ? pixelDataOut1 : pix_q[3], read12 ? pixelDataOut2 : pix_q[2],
                  read34 ? pixelDataOut3 : pix_q[1], read34 ? pixelDataOut4 : pix_q[0]};
    have12_d   = (r34_fall | (erase & ~erase_q)) ? 1'b0 : (read12_q & ~read12) ? 1'b1 : have12_q;
    seq_d      = seq_q + 8'(commit);
    wr_d       = wr_q + AW'(commit);
    rd_d       = rd_q + AW'(pop);
    level_d    = level_q + LW'(commit) - LW'(pop);
    overflow_d = drop | (overflow_q & ~clear_err);
    seq_err_d  = (r34_fall & ~have12_q) | (seq_err_q & ~clear_err);
    cur        = mem[rd_q];
    more       = level_d != '0;
    nidx       = (state_q == IDLE || idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    fi         = 3'd5 - nidx;
    go         = (state_q == IDLE) ? more : adv & ((idx_q != 3'd5) | more);
    stop       = (state_q == SEND) & adv & (idx_q == 3'd5) & ~more;
    state_d    = go ? SEND : stop ? IDLE : state_q;
    idx_d      = go ? nidx : stop ? 3'd0 : idx_q;
    valid_d    = go ? 1'b1 : stop ? 1'b0 : valid_q;
    data_d     = go ? ((nidx == 3'd0) ? HEADER : cur[fi]) : stop ? '0 : data_q;
    last_d     = go ? (nidx == 3'd5) : stop ? 1'b0 : last_q;
  end
  always_ff @(posedge clk)
    if (commit) mem[wr_q] <= {DATA_W'(seq_q), pix_q};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= IDLE;
      read12_q   <= 1'b0;
      read34_q   <= 1'b0;
      erase_q    <= 1'b0;
      have12_q   <= 1'b0;
      pix_q      <= '0;
      seq_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      read12_q   <= read12;
      read34_q   <= read34;
      erase_q    <= erase;
      have12_q   <= have12_d;
      pix_q      <= pix_d;
      seq_q      <= seq_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      level_q    <= level_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      seq_err_q  <= seq_err_d;
    end
  assign out.data  = data_q;
  assign out.valid = valid_q;
  assign out.last  = last_q;
  assign buf_level = level_q;
  assign overflow  = overflow_q;
  assign seq_err   = seq_err_q;
endmodule

// File: tb/tb_pixel_frame_serializer.sv
// tb_pixel_frame_serializer: scoreboard bench for the pixel frame serializer
module tb_pixel_frame_serializer;
  logic       clk = 0, reset = 0, erase = 0, read12 = 0, read34 = 0, clear_err = 0;
  logic [7:0] px1 = 0, px2 = 0, px3 = 0, px4 = 0;
  logic [1:0] buf_level;
  logic       overflow, seq_err;
  logic [8:0] q [$];
  logic [8:0] mon_e;
  logic [7:0] mseq = 0, held = 0;
  logic       stall_q = 0;
  logic [3:0] pat = 4'b1001;
  int         n_err = 0, n_chk = 0;
  pixel_frame_serializer_if #(.DATA_W(8)) out ();
  pixel_frame_serializer dut (
    .clk(clk), .reset(reset), .erase(erase), .read12(read12), .read34(read34),
    .pixelDataOut1(px1), .pixelDataOut2(px2), .pixelDataOut3(px3), .pixelDataOut4(px4),
    .out(out), .buf_level(buf_level), .overflow(overflow), .seq_err(seq_err), .clear_err(clear_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] p1, p2, p3, p4, input bit commit, input int n);
    step();
    erase = 1;
    step();
    erase = 0;
    for (int i = 0; i < n; i++) begin
      read12 = 1;
      px1 = (i == n - 1) ? p1 : 8'($urandom);
      px2 = (i == n - 1) ? p2 : 8'($urandom);
      step();
    end
    read12 = 0;
    for (int i = 0; i < n; i++) begin
      read34 = 1;
      px3 = (i == n - 1) ? p3 : 8'($urandom);
      px4 = (i == n - 1) ? p4 : 8'($urandom);
      step();
    end
    read34 = 0;
    if (commit) begin
      q.push_back({1'b0, 8'hA5});
      q.push_back({1'b0, mseq});
      q.push_back({1'b0, p1});
      q.push_back({1'b0, p2});
      q.push_back({1'b0, p3});
      q.push_back({1'b1, p4});
      mseq++;
    end
  endtask
  task automatic wait_drain(input int lim);
    for (int k = 0; k < lim && q.size() != 0; k++) step();
    chk("drain", q.size(), 0);
  endtask
  initial forever begin
    @(negedge clk);
    if (!reset) stall_q = 0;
    else begin
      if (stall_q && out.valid) chk("hold", out.data, held);
      if (out.valid && out.ready) begin
        if (q.size() == 0) chk("unexpected_byte", q.size(), 1);
        else begin
          mon_e = q.pop_front();
          chk("byte", out.data, mon_e[7:0]);
          chk("last", out.last, mon_e[8]);
        end
      end
      stall_q = out.valid && !out.ready;
      held = out.data;
    end
  end
  initial begin
    int nv;
    out.ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out.valid, 0);
    chk("rst_last", out.last, 0);
    chk("rst_data", out.data, 0);
    chk("rst_level", buf_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_seqerr", seq_err, 0);
    step();
    reset = 1;
    out.ready = 1;
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1, 3);
    @(negedge clk);
    chk("t1_c_valid", out.valid, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t1_valid", out.valid, 1);
      chk("t1_last", out.last, i == 5);
    end
    @(negedge clk);
    chk("t1_idle", out.valid, 0);
    out.ready = 0;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1, 2);
    send_frame(8'h05, 8'h06, 8'h07, 8'h08, 1, 2);
    send_frame(8'h09, 8'h0A, 8'h0B, 8'h0C, 0, 2);
    step();
    chk("t2_level", buf_level, 2);
    chk("t2_ovf", overflow, 1);
    chk("t2_valid", out.valid, 1);
    chk("t2_hdr", out.data, 8'hA5);
    out.ready = 1;
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!out.valid) break;
      nv++;
    end
    chk("t2_burst", nv, 12);
    chk("t2_level0", buf_level, 0);
    chk("t2_sb", q.size(), 0);
    step();
    clear_err = 1;
    step();
    clear_err = 0;
    @(negedge clk);
    chk("t2_ovf_clr", overflow, 0);
    step();
    read34 = 1;
    step();
    read34 = 0;
    step();
    step();
    @(negedge clk);
    chk("t3_seqerr", seq_err, 1);
    chk("t3_nopkt", out.valid, 0);
    chk("t3_level", buf_level, 0);
    step();
    clear_err = 1;
    step();
    clear_err = 0;
    @(negedge clk);
    chk("t3_clr", seq_err, 0);
    step();
    read34 = 1;
    step();
    read34 = 0;
    clear_err = 1;
    step();
    clear_err = 0;
    @(negedge clk);
    chk("t3_err_wins", seq_err, 1);
    step();
    clear_err = 1;
    step();
    clear_err = 0;
    @(negedge clk);
    chk("t3_clr2", seq_err, 0);
    out.ready = 0;
    send_frame(8'h21, 8'h22, 8'h23, 8'h24, 1, 1);
    send_frame(8'h31, 8'h32, 8'h33, 8'h34, 1, 1);
    for (int k = 0; k < 200 && q.size() != 0; k++) begin
      out.ready = pat[k % 4];
      step();
    end
    chk("t4_drain", q.size(), 0);
    out.ready = 1;
    step();
    step();
    for (int f = 0; f < 257; f++) begin
      send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1, 1);
      wait_drain(40);
    end
    step();
    @(negedge clk);
    chk("t5_idle", out.valid, 0);
    out.ready = 0;
    send_frame(8'h61, 8'h62, 8'h63, 8'h64, 1, 1);
    step();
    step();
    out.ready = 1;
    step();
    step();
    step();
    out.ready = 0;
    chk("t6_pending", out.data, 8'h62);
    chk("t6_pvalid", out.valid, 1);
    #2 reset = 0;
    #1;
    chk("t6_async", out.valid, 0);
    chk("t6_level", buf_level, 0);
    q.delete();
    mseq = 0;
    step();
    reset = 1;
    out.ready = 1;
    send_frame(8'h71, 8'h72, 8'h73, 8'h74, 1, 2);
    wait_drain(40);
    step();
    @(negedge clk);
    chk("t6_idle", out.valid, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
